// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state codes, frame
// field widths and the default load address.
package loader_pkg;

    localparam int LEN_W   = 16;
    localparam int CSUM_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_HI = 3'd1;
    localparam state_t ST_LEN_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs accepted data bytes MSB-first into 32-bit words and keeps the running XOR.
// Latency: word_ready pulses one cycle after the 4th byte; word_last flags that byte.
// Backpressure: none, every byte presented on shift_en is consumed.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic              word_last,
    output logic              word_ready,
    output logic [31:0]       word,
    output logic [CSUM_W-1:0] xor_sum
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;

    assign word_last = shift_en && (byte_cnt == 2'd3);
    assign word      = shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= 2'd0;
            shift_q    <= 32'd0;
            xor_sum    <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= word_last && !clear;
            if (clear) begin
                byte_cnt <= 2'd0;
                shift_q  <= 32'd0;
                xor_sum  <= '0;
            end else if (shift_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {shift_q[23:0], byte_in};
                xor_sum  <= xor_sum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length/data/XOR-checksum byte frame into program memory and releases the core.
// Latency: wr_en one cycle after a word's 4th byte; done/cpu_reset_n one cycle after checksum.
// Backpressure: rx_ready held high for the whole frame, low only while idle/done/error.
module program_loader
    import loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_address,
    output logic [31:0] wr_data,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t           state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] index;
    logic [LEN_W-1:0] len_next;
    logic             len_ok;
    logic             accept;
    logic             restart;
    logic             word_last;
    logic             word_ready;
    logic [31:0]      word;
    logic [CSUM_W-1:0] xor_sum;

    assign rx_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_DATA)   || (state == ST_CHECK);
    assign busy        = rx_ready;
    assign done        = (state == ST_DONE);
    assign error       = (state == ST_ERROR);
    assign cpu_reset_n = (state == ST_DONE);

    assign accept  = rx_valid && rx_ready;
    assign restart = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

    assign len_next = {len_hi, rx_data};
    assign len_ok   = (len_next != '0) && ({16'd0, len_next} <= 32'(MEMORY_DEPTH));

    // The write strobe and data come straight from the assembler's registers;
    // the address follows the registered word index.
    assign wr_en      = word_ready;
    assign wr_data    = word;
    assign wr_address = BASE_ADDRESS + {14'd0, index, 2'b00};

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .shift_en   (accept && (state == ST_DATA)),
        .byte_in    (rx_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .word       (word),
        .xor_sum    (xor_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            len_hi <= 8'd0;
            len    <= '0;
            index  <= '0;
        end else begin
            if (restart) begin
                index <= '0;
            end else if (word_ready && (index != len)) begin
                index <= index + 16'd1;
            end

            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) state <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_hi <= rx_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len   <= len_next;
                        state <= len_ok ? ST_DATA : ST_ERROR;
                    end
                end
                ST_DATA: begin
                    // Leave on the byte that completes the last word so a
                    // checksum arriving during its write pulse is not taken as data.
                    if (word_last && (index == len - 16'd1)) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept) state <= (rx_data == xor_sum) ? ST_DONE : ST_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: driver queues expected memory
// writes from a frame-level model, a negedge monitor pops and compares them.
module tb_program_loader;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 32;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .wr_en       (wr_en),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected (t=%0t)",
                         wr_address, wr_data, $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_address", wr_address, e[63:32]);
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xor_of(input word_q_t ws);
        logic [7:0] x = 8'h00;
        foreach (ws[i]) x = x ^ ws[i][31:24] ^ ws[i][23:16] ^ ws[i][15:8] ^ ws[i][7:0];
        return x;
    endfunction

    task automatic check_reset_values();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_wr_address", wr_address, BASE);
        check("rst_wr_data", wr_data, 0);
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic do_start();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        @(negedge clk);
        check("rx_ready_on_start", rx_ready, 0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit with_start);
        int gap;
        bit accepted;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_accept_timeout: byte %h never accepted, rx_ready=%b", b, rx_ready);
        end
    endtask

    task automatic check_outcome(input bit ok);
        check("done", done, 32'(ok));
        check("error", error, 32'(!ok));
        check("cpu_reset_n", cpu_reset_n, 32'(ok));
        check("busy_end", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", exp_q.size(), 0);
    endtask

    // Full frame; start_byte = index of the data byte that also carries start (-1 none)
    task automatic load(input word_q_t ws, input logic [7:0] csum, input int max_gap, input int start_byte);
        logic [15:0] n16;
        logic [31:0] w;
        bit ok;
        n16 = 16'(ws.size());
        ok  = (csum == xor_of(ws));
        do_start();
        foreach (ws[i]) exp_q.push_back({BASE + 32'(4 * i), ws[i]});
        send_byte(n16[15:8], max_gap, 1'b0);
        send_byte(n16[7:0], max_gap, 1'b0);
        foreach (ws[i]) begin
            for (int b = 0; b < 4; b++) begin
                w = ws[i] >> (8 * (3 - b));
                send_byte(w[7:0], max_gap, (4 * i + b) == start_byte);
            end
        end
        send_byte(csum, max_gap, 1'b0);
        check_outcome(ok);
    endtask

    task automatic bad_length(input logic [15:0] n16);
        do_start();
        send_byte(n16[15:8], 0, 1'b0);
        send_byte(n16[7:0], 0, 1'b0);
        check("badlen_error", error, 1);
        check("badlen_done", done, 0);
        check("badlen_cpu_reset_n", cpu_reset_n, 0);
        check("badlen_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        word_q_t ws;
        logic [7:0] cs;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values();

        // Reference words; their XOR is 0x55, so 0x5D must be rejected.
        ws = '{32'h2008_0005, 32'h0109_5020};
        load(ws, xor_of(ws), 0, -1);
        load(ws, 8'h00, 0, -1);
        load(ws, xor_of(ws), 0, -1);
        load(ws, 8'h5D, 0, -1);

        bad_length(16'h0000);
        bad_length(16'(DEPTH + 1));

        load(ws, xor_of(ws), 5, -1);

        // Reset after 6 data bytes: only word 0 gets written.
        do_start();
        exp_q.push_back({BASE, ws[0]});
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h20, 0, 1'b0);
        send_byte(8'h08, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h09, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_values();
        check("reset_pending_writes", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check_reset_values();
        load(ws, xor_of(ws), 0, -1);

        load(ws, xor_of(ws), 0, 5);

        ws = {};
        for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
        load(ws, xor_of(ws), 0, -1);

        for (int t = 0; t < 8; t++) begin
            ws = {};
            for (int i = 0; i < int'($urandom_range(8, 1)); i++) ws.push_back($urandom);
            cs = xor_of(ws);
            if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
            load(ws, cs, 5, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
